avst_packet_arbiter: RTL and testbench

- Packet-level weighted round-robin arbiter that sequences the Avalon-ST multiplexer datapath.
- Watches the head of each source stream and issues a one-hot grant that the mux uses to select its input and route ready.
- Holds the grant from sop to the accepted eop, then re-arbitrates.
- A watchdog releases a grant whose packet stalls.

---
 rtl/avst_packet_arbiter.sv | 165 ++++++++++++++++
 tb/tb_avst_packet_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avst_packet_arbiter.sv
// avst_packet_arbiter: packet-level weighted round-robin arbiter that sequences an
// Avalon-ST multiplexer. A grant is issued from a source's sop and held until the
// mux output accepts the eop. A watchdog releases a grant whose packet stalls.
//
// Ports:
//   i_clk, i_reset_n   clock, synchronous active-low reset
//   i_enable           1 = new grants allowed; 0 = finish current packet only
//   i_src_valid/sop    per-source head-of-stream valid and sop
//   i_weight           packed per-source weights (packets per turn, 0 = masked)
//   i_out_fire/eop     accepted beat / eop at the mux output
//   o_grant            one-hot mux select (all zero when idle)
//   o_grant_idx        binary index of the granted source (holds when idle)
//   o_busy             a grant is active
//   o_pkt_done         one-cycle pulse after the granted packet's eop is accepted
//   o_timeout_err      one-cycle pulse after the watchdog forces release
module avst_packet_arbiter #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned WEIGHT_WIDTH = 4,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic                            i_enable,
  input  logic [NUM_SRC-1:0]              i_src_valid,
  input  logic [NUM_SRC-1:0]              i_src_sop,
  input  logic [NUM_SRC*WEIGHT_WIDTH-1:0] i_weight,
  input  logic                            i_out_fire,
  input  logic                            i_out_eop,
  output logic [NUM_SRC-1:0]              o_grant,
  output logic [$clog2(NUM_SRC)-1:0]      o_grant_idx,
  output logic                            o_busy,
  output logic                            o_pkt_done,
  output logic                            o_timeout_err
);

  localparam int unsigned IdxW = $clog2(NUM_SRC);
  localparam int unsigned WdW  = $clog2(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                  r_state, w_state_nxt;
  logic [NUM_SRC-1:0]      r_grant, w_grant_nxt;
  // r_ptr is both the round-robin pointer and the current/last owner.
  logic [IdxW-1:0]         r_ptr, w_ptr_nxt;
  // Cleared by reset so the first scan starts at index 0 rather than pointer+1.
  logic                    r_ptr_valid, w_ptr_valid_nxt;
  logic [WEIGHT_WIDTH-1:0] r_credit, w_credit_nxt;
  logic [WdW-1:0]          r_wdog, w_wdog_nxt;
  logic                    r_pkt_done, w_pkt_done_nxt;
  logic                    r_timeout_err, w_timeout_err_nxt;

  logic [WEIGHT_WIDTH-1:0] w_weight [NUM_SRC];
  logic [NUM_SRC-1:0]      w_eligible;
  logic [IdxW-1:0]         w_scan_start;
  logic [IdxW-1:0]         w_new_sel;
  logic                    w_continue;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign w_weight[g]   = i_weight[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign w_eligible[g] = i_src_valid[g] & i_src_sop[g] & (w_weight[g] != '0);
  end

  // Owner keeps the grant while it still has credit for this turn.
  assign w_continue = (r_credit != '0) & w_eligible[r_ptr];

  assign w_scan_start = (!r_ptr_valid || (r_ptr == IdxW'(NUM_SRC - 1))) ? '0 : r_ptr + 1'b1;

  // First eligible source scanning circularly from w_scan_start.
  always_comb begin
    logic            found;
    logic [IdxW-1:0] idx;
    found     = 1'b0;
    idx       = '0;
    w_new_sel = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = IdxW'((32'(w_scan_start) + k) % NUM_SRC);
      if (!found && w_eligible[idx]) begin
        found     = 1'b1;
        w_new_sel = idx;
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_ptr_nxt         = r_ptr;
    w_ptr_valid_nxt   = r_ptr_valid;
    w_credit_nxt      = r_credit;
    w_wdog_nxt        = r_wdog;
    w_pkt_done_nxt    = 1'b0;
    w_timeout_err_nxt = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_wdog_nxt = '0;
        if (i_enable && (|w_eligible)) begin
          w_state_nxt = StBusy;
          w_grant_nxt = '0;
          if (w_continue) begin
            w_grant_nxt[r_ptr] = 1'b1;
          end else begin
            w_grant_nxt[w_new_sel] = 1'b1;
            w_ptr_nxt              = w_new_sel;
            w_ptr_valid_nxt        = 1'b1;
            w_credit_nxt           = w_weight[w_new_sel];
          end
        end
      end
      StBusy: begin
        if (i_out_fire && i_out_eop) begin
          // eop takes priority over a coincident watchdog expiry.
          w_credit_nxt   = (r_credit != '0) ? r_credit - 1'b1 : '0;
          w_pkt_done_nxt = 1'b1;
          w_grant_nxt    = '0;
          w_wdog_nxt     = '0;
          w_state_nxt    = StIdle;
        end else if (i_out_fire) begin
          w_wdog_nxt = '0;
        end else if (r_wdog == WdW'(TIMEOUT - 1)) begin
          // Dropping credit forces the next arbitration onto a new turn.
          w_timeout_err_nxt = 1'b1;
          w_grant_nxt       = '0;
          w_credit_nxt      = '0;
          w_wdog_nxt        = '0;
          w_state_nxt       = StIdle;
        end else begin
          w_wdog_nxt = r_wdog + 1'b1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state       <= StIdle;
      r_grant       <= '0;
      r_ptr         <= '0;
      r_ptr_valid   <= 1'b0;
      r_credit      <= '0;
      r_wdog        <= '0;
      r_pkt_done    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_ptr         <= w_ptr_nxt;
      r_ptr_valid   <= w_ptr_valid_nxt;
      r_credit      <= w_credit_nxt;
      r_wdog        <= w_wdog_nxt;
      r_pkt_done    <= w_pkt_done_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_idx   = r_ptr;
  assign o_busy        = (r_state == StBusy);
  assign o_pkt_done    = r_pkt_done;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_avst_packet_arbiter.sv
// tb_avst_packet_arbiter: self-checking bench for avst_packet_arbiter
// (NUM_SRC=4, WEIGHT_WIDTH=4, TIMEOUT=8). Cycle vector table, directed sequences,
// and randomized traffic scored against a packet-level reference model.
module tb_avst_packet_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;
  localparam int TO = 8;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [3:0]  valid;
  logic [3:0]  sop;
  logic [15:0] weight;
  logic        fire;
  logic        eop;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic        busy;
  logic        pkt_done;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  avst_packet_arbiter #(
    .NUM_SRC      (N),
    .WEIGHT_WIDTH (WW),
    .TIMEOUT      (TO)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_enable      (enable),
    .i_src_valid   (valid),
    .i_src_sop     (sop),
    .i_weight      (weight),
    .i_out_fire    (fire),
    .i_out_eop     (eop),
    .o_grant       (grant),
    .o_grant_idx   (grant_idx),
    .o_busy        (busy),
    .o_pkt_done    (pkt_done),
    .o_timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (packet/turn level) ----------------
  bit m_armed = 1'b0;
  bit m_busy, m_started, m_done, m_to;
  int m_owner, m_credit, m_stall, m_start;
  bit m_found;
  logic [3:0] m_el;

  function automatic int wt(input int i);
    logic [15:0] t;
    t = weight >> (i * WW);
    return int'(t[3:0]);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_armed = 1'b1; m_busy = 1'b0; m_started = 1'b0; m_done = 1'b0; m_to = 1'b0;
      m_owner = 0; m_credit = 0; m_stall = 0;
    end else begin
      m_done = 1'b0;
      m_to   = 1'b0;
      if (!m_busy) begin
        for (int i = 0; i < N; i++) m_el[i] = valid[i] & sop[i] & (wt(i) != 0);
        if (enable && m_el != 4'b0) begin
          if (!(m_credit > 0 && m_el[m_owner])) begin
            m_start = m_started ? (m_owner + 1) % N : 0;
            m_found = 1'b0;
            for (int k = 0; k < N; k++) begin
              if (!m_found && m_el[(m_start + k) % N]) begin
                m_found = 1'b1;
                m_owner = (m_start + k) % N;
              end
            end
            m_credit  = wt(m_owner);
            m_started = 1'b1;
          end
          m_busy  = 1'b1;
          m_stall = 0;
        end
      end else if (fire && eop) begin
        if (m_credit > 0) m_credit--;
        m_done = 1'b1;
        m_busy = 1'b0;
      end else if (fire) begin
        m_stall = 0;
      end else begin
        m_stall++;
        if (m_stall == TO) begin
          m_to = 1'b1; m_busy = 1'b0; m_credit = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      chk("model", {23'b0, grant, grant_idx, busy, pkt_done, timeout_err},
          {23'b0, (m_busy ? 4'(1 << m_owner) : 4'b0), 2'(m_owner), m_busy, m_done, m_to});
    end
  end

  // ---------------- cycle vector table ----------------
  typedef struct {
    logic       rst_n, en;
    logic [3:0] valid, sop;
    logic       fire, eop;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       busy, done, to;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic e, input logic [3:0] v, input logic [3:0] s,
                     input logic f, input logic eo, input logic [3:0] g, input logic [1:0] ix,
                     input logic b, input logic d, input logic t);
    vec_t x;
    x.rst_n = r; x.en = e; x.valid = v; x.sop = s; x.fire = f; x.eop = eo;
    x.grant = g; x.idx = ix; x.busy = b; x.done = d; x.to = t;
    vq.push_back(x);
  endtask

  int exp_q[$];

  // Constant backlog with 1-beat packets; each grant followed by one idle cycle.
  task automatic rr_seq(input logic [15:0] w, input string nm);
    weight = w; valid = 4'hF; sop = 4'hF; enable = 1'b1; fire = 1'b1; eop = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    foreach (exp_q[p]) begin
      tick();
      chk($sformatf("%s_grant%0d", nm, p), 32'(grant), 32'(1 << exp_q[p]));
      tick();
      chk($sformatf("%s_bubble%0d", nm, p), 32'(grant), 32'h0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  int to_cnt, done_cnt, busy_cnt, mode;

  initial begin
    rst_n = 1'b0; enable = 1'b1; valid = '0; sop = '0; weight = 16'h1111;
    fire = 1'b0; eop = 1'b0;

    // Single source, eop/timeout collision, watchdog release.
    add(0, 1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 1, 4'b0100, 4'b0100, 0, 0, 4'b0100, 2, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 4'b0100, 4'b0000, 1, 0, 4'b0100, 2, 1, 0, 0);
    add(1, 1, 4'b0100, 4'b0000, 1, 1, 4'b0000, 2, 0, 1, 0);
    add(1, 1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 2, 0, 0, 0);
    add(1, 1, 4'b0001, 4'b0001, 0, 0, 4'b0001, 0, 1, 0, 0);
    for (int i = 0; i < TO - 1; i++) add(1, 1, 4'b0000, 4'b0000, 0, 0, 4'b0001, 0, 1, 0, 0);
    add(1, 1, 4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 0, 1, 0);
    add(1, 1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 1, 4'b0010, 4'b0010, 0, 0, 4'b0010, 1, 1, 0, 0);
    for (int i = 0; i < TO - 1; i++) add(1, 1, 4'b0010, 4'b0010, 0, 0, 4'b0010, 1, 1, 0, 0);
    add(1, 1, 4'b0010, 4'b0010, 0, 0, 4'b0000, 1, 0, 0, 1);
    add(1, 1, 4'b1111, 4'b1111, 0, 0, 4'b0100, 2, 1, 0, 0);
    add(1, 1, 4'b0000, 4'b0000, 1, 1, 4'b0000, 2, 0, 1, 0);
    add(1, 1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 2, 0, 0, 0);

    foreach (vq[i]) begin
      rst_n = vq[i].rst_n; enable = vq[i].en; valid = vq[i].valid; sop = vq[i].sop;
      fire = vq[i].fire; eop = vq[i].eop;
      tick();
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vq[i].grant));
      chk($sformatf("vec%0d_idx", i), 32'(grant_idx), 32'(vq[i].idx));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vq[i].busy));
      chk($sformatf("vec%0d_done", i), 32'(pkt_done), 32'(vq[i].done));
      chk($sformatf("vec%0d_to", i), 32'(timeout_err), 32'(vq[i].to));
    end

    // Plain round robin, then weights {3,1,0,2} for sources 0..3.
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    rr_seq(16'h1111, "rr");
    exp_q = '{0, 0, 0, 1, 3, 3, 0, 0, 0, 1, 3, 3};
    rr_seq({4'd2, 4'd0, 4'd1, 4'd3}, "wrr");

    // Alternating backpressure: never trips the watchdog.
    weight = 16'h1111; rst_n = 1'b0; fire = 1'b0; eop = 1'b0;
    tick();
    rst_n = 1'b1; valid = 4'b0001; sop = 4'b0001; enable = 1'b1;
    tick();
    chk("bp_grant", 32'(grant), 32'h1);
    valid = '0; sop = '0; to_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 13; c++) begin
      fire = (c % 2 == 0) && (c < 12);
      eop  = (c == 10);
      tick();
      to_cnt   += int'(timeout_err);
      done_cnt += int'(pkt_done);
    end
    chk("bp_timeout", 32'(to_cnt), 32'd0);
    chk("bp_done", 32'(done_cnt), 32'd1);

    // enable dropped mid-packet: packet completes, then no grants.
    fire = 1'b0; eop = 1'b0; valid = 4'b0001; sop = 4'b0001; enable = 1'b1;
    tick();
    chk("en_grant", 32'(grant), 32'h1);
    enable = 1'b0; valid = '0; sop = '0; fire = 1'b1;
    tick();
    tick();
    tick();
    chk("en_hold", 32'(busy), 32'd1);
    eop = 1'b1;
    tick();
    chk("en_done", 32'(pkt_done), 32'd1);
    fire = 1'b0; eop = 1'b0; valid = 4'hF; sop = 4'hF; busy_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      busy_cnt += int'(busy);
    end
    chk("en_blocked", 32'(busy_cnt), 32'd0);
    enable = 1'b1;
    tick();
    chk("en_resume", 32'(grant), 32'h2);
    fire = 1'b1; eop = 1'b1;
    tick();

    // Reset in BUSY; first grant afterwards goes to the lowest eligible index.
    fire = 1'b0; eop = 1'b0; valid = 4'b0010; sop = 4'b0010;
    tick();
    chk("mr_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_busy", 32'(busy), 32'd0);
    rst_n = 1'b1; valid = 4'b1001; sop = 4'b1001;
    tick();
    chk("mr_first", 32'(grant), 32'h1);
    fire = 1'b1; eop = 1'b1;
    tick();

    // Randomized traffic, scored by the model every cycle.
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) mode = int'($urandom_range(0, 1));
      rst_n  = ($urandom_range(0, 299) != 0);
      enable = ($urandom_range(0, 7) != 0);
      valid  = 4'($urandom);
      sop    = 4'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        for (int i = 0; i < N; i++) weight[i*WW +: WW] = 4'($urandom_range(0, 3));
      end
      fire = (mode == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      eop  = ($urandom_range(0, 3) == 0);
      tick();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
